// File: rtl/mips_pkg.sv
// Shared constants and dump FSM encoding for the MIPS register file.
//   DATA_W   : register width in bits
//   ADDR_W   : register index width (register count = 2**ADDR_W)
//   REG_ZERO : index of the hardwired-zero register ($zero)
//   dump_state_t : dump engine states IDLE / STREAM / DONE
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_t;

endpackage : mips_pkg

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks every register index once over a valid/ready stream.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   dump_req              : one-cycle start pulse, honoured only when idle
//   dump_ready            : consumer accepts the current beat
//   dump_busy, dump_valid : stream status (registered)
//   dump_index            : index of the current beat (registered)
//   rd_index_c            : index driven into the array's dump read port
module regfile_dump_fsm #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [ADDR_W-1:0] rd_index_c
);

    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_INDEX = {ADDR_W{1'b1}};

    dump_state_t       state_q, state_n;
    logic [ADDR_W-1:0] index_q, index_n;
    logic              busy_q, busy_n;
    logic              valid_q, valid_n;

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            index_q <= index_n;
            busy_q  <= busy_n;
            valid_q <= valid_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state_q;
        index_n = index_q;
        busy_n  = busy_q;
        valid_n = valid_q;

        case (state_q)
            IDLE: begin
                busy_n  = 1'b0;
                valid_n = 1'b0;
                if (dump_req) begin
                    state_n = STREAM;
                    index_n = '0;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                end
            end

            STREAM: begin
                if (valid_q && dump_ready) begin
                    if (index_q == LAST_INDEX) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        valid_n = 1'b0;
                    end else begin
                        // Guarded at LAST_INDEX, so this never wraps
                        index_n = index_q + ADDR_W'(1);
                    end
                end
            end

            DONE: begin
                // Single idle gap between consecutive dumps
                state_n = IDLE;
                busy_n  = 1'b0;
                valid_n = 1'b0;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_index = index_q;
    assign rd_index_c = index_q;

endmodule : regfile_dump_fsm

// File: rtl/mips_register_file.sv
// MIPS general-purpose register file with $zero hardwired to 0.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   rs_addr/rs_data   : combinational read port A
//   rt_addr/rt_data   : combinational read port B
//   wr_en/wr_addr/wr_data : synchronous write port (writes to r0 dropped)
//   dump_req, dump_ready, dump_busy, dump_valid, dump_index, dump_data :
//                       full-register dump stream over valid/ready
// BYPASS=1 forwards a same-cycle write to every read port, dump included.
module mips_register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data
);

    import mips_pkg::*;

    localparam int unsigned REG_COUNT = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [ADDR_W-1:0] dump_rd_index_c;

    // Read one port: r0 reads zero, optional same-cycle write forwarding
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] value;
        if (addr == ZERO_IDX) begin
            value = '0;
        end else if ((BYPASS != 0) && w_en && (w_addr == addr)) begin
            value = w_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Storage: reset clears everything and takes priority over a write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_IDX)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Three combinational read ports: rs, rt and the dump engine
    always_comb begin
        rs_data   = read_port(rs_addr, regs[rs_addr], wr_en, wr_addr, wr_data);
        rt_data   = read_port(rt_addr, regs[rt_addr], wr_en, wr_addr, wr_data);
        dump_data = read_port(dump_rd_index_c, regs[dump_rd_index_c],
                              wr_en, wr_addr, wr_data);
    end

    regfile_dump_fsm #(
        .ADDR_W (ADDR_W)
    ) u_dump_fsm (
        .clock      (clock),
        .reset      (reset),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_index (dump_index),
        .rd_index_c (dump_rd_index_c)
    );

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file. Two instances share all inputs:
// dut with forwarding enabled and dut_nb with forwarding disabled. Expected
// values come from a plain array model of the 32 registers.
module tb_mips_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        dump_req, dump_ready;

    logic [31:0] rs_data, rt_data, dump_data;
    logic        dump_busy, dump_valid;
    logic [4:0]  dump_index;

    logic [31:0] nb_rs_data, nb_rt_data, nb_dump_data;
    logic        nb_dump_busy, nb_dump_valid;
    logic [4:0]  nb_dump_index;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [32];

    always #5 clock = ~clock;

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data)
    );

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(nb_rs_data), .rt_data(nb_rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_req(dump_req), .dump_busy(nb_dump_busy), .dump_valid(nb_dump_valid),
        .dump_ready(dump_ready), .dump_index(nb_dump_index), .dump_data(nb_dump_data)
    );

    // Architectural read: r0 is zero, forwarding optionally sees the pending write
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bypass);
        if (a == 5'd0) return 32'h0;
        if (bypass && wr_en && (wr_addr == a)) return wr_data;
        return model[a];
    endfunction

    // Advance one clock; the model commits at the edge, then we park on negedge
    task automatic step();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            model[wr_addr] = wr_data;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom;
        step(); step();
        reset = 1'b0; wr_en = 1'b0;
        #1;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_dump_state: busy=%b valid=%b index=%0d, required 0/0/0",
                     dump_busy, dump_valid, dump_index);
        end
        step();
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            vectors++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0 ||
                nb_rs_data !== 32'h0 || nb_rt_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_read r%0d: rs=%h rt=%h nb_rs=%h nb_rt=%h, required 0",
                         i, rs_data, rt_data, nb_rs_data, nb_rt_data);
            end
            step();
        end
    endtask

    task automatic test_write_readback();
        wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'hDEADBEEF; step();
        wr_addr = 5'd31; wr_data = 32'h12345678; step();
        wr_en = 1'b0; rs_addr = 5'd5; rt_addr = 5'd31;
        #1;
        vectors++;
        if (rs_data !== 32'hDEADBEEF || nb_rs_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL readback_r5: got %h/%h, required DEADBEEF", rs_data, nb_rs_data);
        end
        vectors++;
        if (rt_data !== 32'h12345678 || nb_rt_data !== 32'h12345678) begin
            errors++;
            $display("FAIL readback_r31: got %h/%h, required 12345678", rt_data, nb_rt_data);
        end
        step();
    endtask

    task automatic test_r0_protection();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        vectors++;
        if (rs_data !== 32'h0 || nb_rs_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_write_cycle: got %h/%h, required 0", rs_data, nb_rs_data);
        end
        step();
        wr_en = 1'b0;
        #1;
        vectors++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || nb_rt_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_after_write: got %h/%h/%h, required 0",
                     rs_data, rt_data, nb_rt_data);
        end
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] old_val;
        old_val = model[7];
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rs_addr = 5'd7; rt_addr = 5'd5;
        #1;
        vectors++;
        if (rs_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_on: got %h, required A5A5A5A5", rs_data);
        end
        vectors++;
        if (nb_rs_data !== old_val) begin
            errors++;
            $display("FAIL bypass_off: got %h, required %h", nb_rs_data, old_val);
        end
        step();
        wr_en = 1'b0;
        #1;
        vectors++;
        if (nb_rs_data !== 32'hA5A5A5A5 || rs_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_committed: got %h/%h, required A5A5A5A5",
                     rs_data, nb_rs_data);
        end
        step();
    endtask

    task automatic test_random_rw();
        for (int n = 0; n < 400; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (rs_data !== exp_read(rs_addr, 1'b1) || rt_data !== exp_read(rt_addr, 1'b1)) begin
                errors++;
                $display("FAIL random_bypass rs=%0d rt=%0d: got %h/%h, required %h/%h",
                         rs_addr, rt_addr, rs_data, rt_data,
                         exp_read(rs_addr, 1'b1), exp_read(rt_addr, 1'b1));
            end
            vectors++;
            if (nb_rs_data !== exp_read(rs_addr, 1'b0) || nb_rt_data !== exp_read(rt_addr, 1'b0)) begin
                errors++;
                $display("FAIL random_nobypass rs=%0d rt=%0d: got %h/%h, required %h/%h",
                         rs_addr, rt_addr, nb_rs_data, nb_rt_data,
                         exp_read(rs_addr, 1'b0), exp_read(rt_addr, 1'b0));
            end
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_dump_backpressure();
        int          beats;
        int          cyc;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
            step();
        end
        wr_en = 1'b0;
        dump_req = 1'b1; step(); dump_req = 1'b0;
        beats = 0; cyc = 0; exp_idx = 5'd0;
        while (beats < 32 && cyc < 200) begin
            dump_ready = (cyc % 3 == 0);
            dump_req   = (cyc == 7);
            #1;
            exp_data = 32'(exp_idx) * 32'h01010101;
            vectors++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_index !== exp_idx ||
                dump_data !== exp_data) begin
                errors++;
                $display("FAIL dump_bp_beat%0d: valid=%b busy=%b idx=%0d data=%h, required 1/1/%0d/%h",
                         beats, dump_valid, dump_busy, dump_index, dump_data, exp_idx, exp_data);
            end
            if (dump_valid && dump_ready) begin
                beats++;
                exp_idx = exp_idx + 5'd1;
            end
            cyc++;
            step();
        end
        dump_req = 1'b0;
        vectors++;
        if (beats != 32) begin
            errors++;
            $display("FAIL dump_bp_timeout: %0d beats, required 32", beats);
        end
        // DONE cycle: a request here must be ignored
        dump_ready = 1'b0; dump_req = 1'b1;
        #1;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_done_cycle: busy=%b valid=%b, required 0/0", dump_busy, dump_valid);
        end
        step();
        dump_req = 1'b0;
        #1;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_req_in_done_ignored: busy=%b valid=%b, required 0/0",
                     dump_busy, dump_valid);
        end
        step();
    endtask

    task automatic test_dump_concurrent_writes();
        int         beats;
        int         cyc;
        logic [4:0] exp_idx;
        dump_req = 1'b1; step(); dump_req = 1'b0;
        beats = 0; cyc = 0; exp_idx = 5'd0;
        while (beats < 32 && cyc < 400) begin
            dump_ready = 1'($urandom_range(0, 1));
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = ($urandom_range(0, 2) == 0) ? exp_idx : 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            #1;
            vectors++;
            if (dump_valid !== 1'b1 || dump_index !== exp_idx ||
                dump_data !== exp_read(exp_idx, 1'b1)) begin
                errors++;
                $display("FAIL dump_wr_beat%0d: valid=%b idx=%0d data=%h, required 1/%0d/%h",
                         beats, dump_valid, dump_index, dump_data, exp_idx, exp_read(exp_idx, 1'b1));
            end
            if (dump_valid && dump_ready) begin
                beats++;
                exp_idx = exp_idx + 5'd1;
            end
            cyc++;
            step();
        end
        wr_en = 1'b0; dump_ready = 1'b0;
        vectors++;
        if (beats != 32) begin
            errors++;
            $display("FAIL dump_wr_timeout: %0d beats, required 32", beats);
        end
        step(); step();
    endtask

    task automatic test_reset_mid_dump();
        int         beats;
        int         cyc;
        logic [4:0] exp_idx;
        dump_req = 1'b1; step(); dump_req = 1'b0;
        dump_ready = 1'b1;
        beats = 0; cyc = 0; exp_idx = 5'd0;
        while (beats < 11 && cyc < 50) begin
            #1;
            vectors++;
            if (dump_valid !== 1'b1 || dump_index !== exp_idx) begin
                errors++;
                $display("FAIL mid_dump_beat%0d: valid=%b idx=%0d, required 1/%0d",
                         beats, dump_valid, dump_index, exp_idx);
            end
            if (dump_valid) begin
                beats++;
                exp_idx = exp_idx + 5'd1;
            end
            cyc++;
            step();
        end
        // Reset with a colliding write: reset must win
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = $urandom;
        step();
        reset = 1'b0; wr_en = 1'b0;
        #1;
        vectors++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_index !== 5'd0) begin
            errors++;
            $display("FAIL mid_dump_reset: valid=%b busy=%b idx=%0d, required 0/0/0",
                     dump_valid, dump_busy, dump_index);
        end
        dump_ready = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            rs_addr = 5'(i); rt_addr = 5'(i + 1);
            #1;
            vectors++;
            if (rs_data !== model[i] || rt_data !== model[i + 1] ||
                rs_data !== 32'h0 || rt_data !== 32'h0) begin
                errors++;
                $display("FAIL mid_dump_cleared r%0d/r%0d: got %h/%h, required 0",
                         i, i + 1, rs_data, rt_data);
            end
            step();
        end
        dump_req = 1'b1; step(); dump_req = 1'b0;
        #1;
        vectors++;
        if (dump_valid !== 1'b1 || dump_index !== 5'd0 || dump_data !== 32'h0) begin
            errors++;
            $display("FAIL dump_restart: valid=%b idx=%0d data=%h, required 1/0/0",
                     dump_valid, dump_index, dump_data);
        end
        dump_ready = 1'b1;
        for (int i = 0; i < 34; i++) step();
        dump_ready = 1'b0;
        #1;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_restart_drain: busy=%b valid=%b, required 0/0",
                     dump_busy, dump_valid);
        end
    endtask

    initial begin
        reset = 1'b1; rs_addr = '0; rt_addr = '0; wr_addr = '0;
        wr_en = 1'b0; wr_data = '0; dump_req = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clock);
        test_reset();
        test_write_readback();
        test_r0_protection();
        test_bypass();
        test_random_rw();
        test_dump_backpressure();
        test_dump_concurrent_writes();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_mips_register_file
